// File: rtl/alu_pipe_if.sv
// Operand-issue / writeback bundle for alu_pipe_param.
// The master issues operations and consumes results; the slave is the ALU pipe.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             din_l;
  logic             din_r;
  logic [3:0]       sel;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             cout;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, din_l, din_r, sel, shamt, out_ready,
    input  in_ready, out_valid, f, cout, zero, neg, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, din_l, din_r, sel, shamt, out_ready,
    output in_ready, out_valid, f, cout, zero, neg, ovf
  );
endinterface

// File: rtl/alu_pipe_param.sv
// Pipelined ALU with valid/ready handshakes on both sides.
// Opcodes: 0..3 adder variants (A + Y + Cin), 4..7 bitwise logic,
// 10xx right shift with din_l fill, 11xx left shift with din_r fill.
// Each stage is an elastic slot; with STAGES=2 a register slot for the
// operands precedes the compute, with STAGES=1 the compute is fed
// directly from the inputs. The output slot is common to both depths.
module alu_pipe_param #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("alu_pipe_param: STAGES must be 1 or 2");
  end
  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("alu_pipe_param: WIDTH must be a power of 2 and >= 4");
  end

  typedef struct packed {
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             ovf;
  } res_t;

  // Single-cycle evaluation of one operation; cout/ovf only meaningful for the adder ops.
  function automatic res_t alu_eval(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic             cin,
                                    input logic             din_l,
                                    input logic             din_r,
                                    input logic [3:0]       sel,
                                    input logic [SHW-1:0]   shamt);
    res_t               r;
    logic [WIDTH-1:0]   y;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] wide;
    r    = '0;
    y    = '0;
    sum  = '0;
    wide = '0;
    case (sel[3:2])
      2'b10: begin
        // Fill bits sit above A so they slide into the vacated MSBs.
        wide = {{WIDTH{din_l}}, a} >> shamt;
        r.f  = wide[WIDTH-1:0];
      end
      2'b11: begin
        // Fill bits sit below A so they slide into the vacated LSBs.
        wide = {a, {WIDTH{din_r}}} << shamt;
        r.f  = wide[2*WIDTH-1:WIDTH];
      end
      2'b01: begin
        case (sel[1:0])
          2'b00:   r.f = a & b;
          2'b01:   r.f = a | b;
          2'b10:   r.f = a ^ b;
          default: r.f = ~a;
        endcase
      end
      default: begin
        case (sel[1:0])
          2'b00:   y = '0;
          2'b01:   y = b;
          2'b10:   y = ~b;
          default: y = '1;
        endcase
        sum    = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        r.f    = sum[WIDTH-1:0];
        r.cout = sum[WIDTH];
        r.ovf  = (a[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
    endcase
    return r;
  endfunction

  // Operation presented to the compute logic, from stage-1 regs or straight from the inputs.
  logic             op_vld;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             op_din_l;
  logic             op_din_r;
  logic [3:0]       op_sel;
  logic [SHW-1:0]   op_shamt;
  logic             slot_free;
  logic             in_ready_w;
  logic             load_out;

  // Output slot registers.
  logic             vld_p2;
  logic [WIDTH-1:0] f_p2;
  logic             cout_p2;
  logic             zero_p2;
  logic             neg_p2;
  logic             ovf_p2;

  res_t             res;

  // The output slot accepts new contents when empty or when its result leaves this cycle.
  assign load_out   = !vld_p2 || bus.out_ready;
  assign in_ready_w = !rst && slot_free;

  if (STAGES == 2) begin : g_two
    logic             vld_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic             cin_p1;
    logic             din_l_p1;
    logic             din_r_p1;
    logic [3:0]       sel_p1;
    logic [SHW-1:0]   shamt_p1;

    // --- stage 1: operand capture ---
    // Slot-1 occupancy; refilled (or emptied) whenever it can accept.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p1 <= 1'b0;
      end else if (in_ready_w) begin
        vld_p1 <= bus.in_valid;
      end
    end

    // Slot-1 payload; no reset needed since vld_p1 qualifies it.
    always_ff @(posedge clk) begin
      if (in_ready_w && bus.in_valid) begin
        a_p1     <= bus.a;
        b_p1     <= bus.b;
        cin_p1   <= bus.cin;
        din_l_p1 <= bus.din_l;
        din_r_p1 <= bus.din_r;
        sel_p1   <= bus.sel;
        shamt_p1 <= bus.shamt;
      end
    end

    assign slot_free = !vld_p1 || load_out;
    assign op_vld    = vld_p1;
    assign op_a      = a_p1;
    assign op_b      = b_p1;
    assign op_cin    = cin_p1;
    assign op_din_l  = din_l_p1;
    assign op_din_r  = din_r_p1;
    assign op_sel    = sel_p1;
    assign op_shamt  = shamt_p1;
  end else begin : g_one
    assign slot_free = load_out;
    assign op_vld    = bus.in_valid;
    assign op_a      = bus.a;
    assign op_b      = bus.b;
    assign op_cin    = bus.cin;
    assign op_din_l  = bus.din_l;
    assign op_din_r  = bus.din_r;
    assign op_sel    = bus.sel;
    assign op_shamt  = bus.shamt;
  end

  // Combinational compute between the operand source and the output slot.
  always_comb begin
    res = alu_eval(op_a, op_b, op_cin, op_din_l, op_din_r, op_sel, op_shamt);
  end

  // --- output stage: result capture ---
  // Output slot; payload only changes on a real load so it stays frozen under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      f_p2    <= '0;
      cout_p2 <= 1'b0;
      zero_p2 <= 1'b0;
      neg_p2  <= 1'b0;
      ovf_p2  <= 1'b0;
    end else if (load_out) begin
      vld_p2 <= op_vld;
      if (op_vld) begin
        f_p2    <= res.f;
        cout_p2 <= res.cout;
        zero_p2 <= (res.f == '0);
        neg_p2  <= res.f[WIDTH-1];
        ovf_p2  <= res.ovf;
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = vld_p2;
  assign bus.f         = f_p2;
  assign bus.cout      = cout_p2;
  assign bus.zero      = zero_p2;
  assign bus.neg       = neg_p2;
  assign bus.ovf       = ovf_p2;
endmodule

// File: tb/tb_alu_pipe_param.sv
// Bench for alu_pipe_param: a 32-bit two-stage instance and a 16-bit
// single-stage instance, directed vectors plus randomized traffic
// scored against an arithmetic reference model.
module tb_alu_pipe_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(32)) b32 ();
  alu_pipe_if #(.WIDTH(16)) b16 ();

  alu_pipe_param #(.WIDTH(32), .STAGES(2)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
  alu_pipe_param #(.WIDTH(16), .STAGES(1)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        dl;
    logic        dr;
    logic [3:0]  sel;
    logic [4:0]  sh;
  } stim_t;

  int          n_chk = 0;
  int          n_err = 0;
  logic [35:0] q32[$];
  logic [35:0] q16[$];
  logic [35:0] prev32, prev16;
  bit          stall32 = 1'b0;
  bit          stall16 = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {f, cout, zero, neg, ovf} from the opcode rules with plain integer arithmetic.
  function automatic logic [35:0] model(input int w, input stim_t s);
    logic [63:0] mask, a, b, y, sum, r;
    logic        c, o;
    int          sh;
    mask = (64'd1 << w) - 64'd1;
    a    = {32'd0, s.a} & mask;
    b    = {32'd0, s.b} & mask;
    sh   = int'(s.sh) % w;
    c    = 1'b0;
    o    = 1'b0;
    y    = 64'd0;
    if (s.sel[3] && !s.sel[2])
      r = (a >> sh) | (s.dl ? (mask & ~(mask >> sh)) : 64'd0);
    else if (s.sel[3])
      r = ((a << sh) & mask) | (s.dr ? ((64'd1 << sh) - 64'd1) : 64'd0);
    else if (s.sel[2]) begin
      case (s.sel[1:0])
        2'd0:    r = a & b;
        2'd1:    r = a | b;
        2'd2:    r = a ^ b;
        default: r = ~a & mask;
      endcase
    end else begin
      case (s.sel[1:0])
        2'd0:    y = 64'd0;
        2'd1:    y = b;
        2'd2:    y = ~b & mask;
        default: y = mask;
      endcase
      sum = a + y + {63'd0, s.cin};
      r   = sum & mask;
      c   = sum[w];
      o   = (a[w-1] == y[w-1]) && (r[w-1] != a[w-1]);
    end
    return {r[31:0], c, (r == 64'd0), r[w-1], o};
  endfunction

  function automatic stim_t mk(input logic [31:0] a, input logic [31:0] b, input logic cin,
                               input logic dl, input logic dr, input logic [3:0] sel,
                               input logic [4:0] sh);
    stim_t s;
    s.a = a; s.b = b; s.cin = cin; s.dl = dl; s.dr = dr; s.sel = sel; s.sh = sh;
    return s;
  endfunction

  function automatic stim_t rnd_stim(input int w);
    stim_t s;
    s.a   = $urandom;
    s.b   = $urandom;
    if ($urandom_range(0, 7) == 0) s.a = (w == 16) ? 32'h0000_7fff : 32'h7fff_ffff;
    if ($urandom_range(0, 7) == 0) s.b = 32'hffff_ffff;
    if (w == 16) begin
      s.a[31:16] = 16'd0;
      s.b[31:16] = 16'd0;
    end
    s.cin = 1'($urandom_range(0, 1));
    s.dl  = 1'($urandom_range(0, 1));
    s.dr  = 1'($urandom_range(0, 1));
    s.sel = 4'($urandom_range(0, 15));
    s.sh  = 5'($urandom_range(0, w - 1));
    return s;
  endfunction

  // One clock of traffic on the 32-bit pipe: drive, settle, check, update scoreboard.
  task automatic step32(input bit v, input stim_t s, input bit ordy, output bit ifire, output bit ofire);
    logic [35:0] obs;
    int          n;
    @(negedge clk);
    b32.in_valid = v;     b32.a = s.a;       b32.b = s.b;        b32.cin = s.cin;
    b32.din_l = s.dl;     b32.din_r = s.dr;  b32.sel = s.sel;    b32.shamt = s.sh;
    b32.out_ready = ordy;
    #1;
    obs = {b32.f, b32.cout, b32.zero, b32.neg, b32.ovf};
    n   = q32.size();
    check_eq("in_ready32", 64'(b32.in_ready), 64'((n == 2 && !ordy) ? 0 : 1));
    if (n == 0) check_eq("idle32", 64'(b32.out_valid), 64'd0);
    if (stall32) check_eq("hold32", 64'({b32.out_valid, obs}), 64'({1'b1, prev32}));
    ofire = b32.out_valid && ordy;
    ifire = v && b32.in_ready;
    if (ofire && n > 0) check_eq("res32", 64'(obs), 64'(q32.pop_front()));
    if (ifire) q32.push_back(model(32, s));
    stall32 = b32.out_valid && !ordy;
    prev32  = obs;
  endtask

  // Same for the 16-bit single-stage pipe.
  task automatic step16(input bit v, input stim_t s, input bit ordy, output bit ifire, output bit ofire);
    logic [35:0] obs;
    int          n;
    @(negedge clk);
    b16.in_valid = v;     b16.a = s.a[15:0]; b16.b = s.b[15:0]; b16.cin = s.cin;
    b16.din_l = s.dl;     b16.din_r = s.dr;  b16.sel = s.sel;   b16.shamt = s.sh[3:0];
    b16.out_ready = ordy;
    #1;
    obs = {16'd0, b16.f, b16.cout, b16.zero, b16.neg, b16.ovf};
    n   = q16.size();
    check_eq("in_ready16", 64'(b16.in_ready), 64'((n == 1 && !ordy) ? 0 : 1));
    if (n == 0) check_eq("idle16", 64'(b16.out_valid), 64'd0);
    if (stall16) check_eq("hold16", 64'({b16.out_valid, obs}), 64'({1'b1, prev16}));
    ofire = b16.out_valid && ordy;
    ifire = v && b16.in_ready;
    if (ofire && n > 0) check_eq("res16", 64'(obs), 64'(q16.pop_front()));
    if (ifire) q16.push_back(model(16, s));
    stall16 = b16.out_valid && !ordy;
    prev16  = obs;
  endtask

  // Single op through the empty 32-bit pipe: exact 2-clock latency and a fixed expected result.
  task automatic dir32(input string tag, input stim_t s, input logic [35:0] exp);
    bit fi, fo;
    step32(1'b1, s, 1'b1, fi, fo);
    step32(1'b0, s, 1'b1, fi, fo);
    check_eq("lat1_32", 64'(b32.out_valid), 64'd0);
    step32(1'b0, s, 1'b1, fi, fo);
    check_eq("lat2_32", 64'(b32.out_valid), 64'd1);
    check_eq(tag, 64'({b32.f, b32.cout, b32.zero, b32.neg, b32.ovf}), 64'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    bit    fi, fo, saw_full;
    int    sent, outs, cyc;

    b32.in_valid = 1'b0; b32.a = '0; b32.b = '0; b32.cin = 1'b0; b32.din_l = 1'b0;
    b32.din_r = 1'b0; b32.sel = '0; b32.shamt = '0; b32.out_ready = 1'b0;
    b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.cin = 1'b0; b16.din_l = 1'b0;
    b16.din_r = 1'b0; b16.sel = '0; b16.shamt = '0; b16.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    b32.in_valid = 1'b1;
    b16.in_valid = 1'b1;
    #1;
    check_eq("rst_out32", 64'({b32.out_valid, b32.f, b32.cout, b32.zero, b32.neg, b32.ovf}), 64'd0);
    check_eq("rst_rdy32", 64'(b32.in_ready), 64'd0);
    check_eq("rst_out16", 64'({b16.out_valid, b16.f, b16.cout, b16.zero, b16.neg, b16.ovf}), 64'd0);
    check_eq("rst_rdy16", 64'(b16.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    b32.in_valid = 1'b0;
    b16.in_valid = 1'b0;

    dir32("inc_wrap",  mk(32'hffff_ffff, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 5'd0), {32'h0000_0000, 4'b1100});
    dir32("sub_pos",   mk(32'h4, 32'h3, 1'b1, 1'b0, 1'b0, 4'h2, 5'd0),         {32'h0000_0001, 4'b1000});
    dir32("sub_neg",   mk(32'h3, 32'h4, 1'b1, 1'b0, 1'b0, 4'h2, 5'd0),         {32'hffff_ffff, 4'b0010});
    dir32("add_noovf", mk(32'h8000_0000, 32'h7fff_ffff, 1'b0, 1'b0, 1'b0, 4'h1, 5'd0), {32'hffff_ffff, 4'b0010});
    dir32("add_ovf",   mk(32'h7fff_ffff, 32'h1, 1'b0, 1'b0, 1'b0, 4'h1, 5'd0), {32'h8000_0000, 4'b0011});
    dir32("dec_ovf",   mk(32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 4'h3, 5'd0), {32'h7fff_ffff, 4'b1001});
    dir32("shr_fill",  mk(32'h1234_5678, 32'h0, 1'b1, 1'b1, 1'b0, 4'h8, 5'd1), {32'h891a_2b3c, 4'b0010});
    dir32("shl_fill",  mk(32'h1234_5678, 32'h0, 1'b1, 1'b0, 1'b1, 4'hc, 5'd4), {32'h2345_678f, 4'b0000});
    dir32("shl_zero",  mk(32'h1234_5678, 32'h0, 1'b1, 1'b1, 1'b1, 4'hd, 5'd0), {32'h1234_5678, 4'b0000});
    dir32("and_op",    mk(32'hf0f0_f0f0, 32'hff00_ff00, 1'b1, 1'b0, 1'b0, 4'h4, 5'd0), {32'hf000_f000, 4'b0010});
    dir32("not_op",    mk(32'hffff_ffff, 32'h0, 1'b1, 1'b0, 1'b0, 4'h7, 5'd0), {32'h0000_0000, 4'b0100});

    step16(1'b1, mk(32'h7fff, 32'h1, 1'b0, 1'b0, 1'b0, 4'h1, 5'd0), 1'b1, fi, fo);
    step16(1'b0, s, 1'b1, fi, fo);
    check_eq("lat1_16", 64'(b16.out_valid), 64'd1);
    check_eq("add_ovf16", 64'({b16.f, b16.cout, b16.zero, b16.neg, b16.ovf}), 64'({16'h8000, 4'b0011}));
    step16(1'b0, s, 1'b1, fi, fo);

    // Six back-to-back ops with the consumer stalled for cycles 3..7.
    sent = 0; outs = 0; cyc = 0; saw_full = 1'b0;
    while (outs < 6 && cyc < 40) begin
      s = rnd_stim(32);
      step32(sent < 6, s, !(cyc >= 3 && cyc <= 7), fi, fo);
      if (fi) sent++;
      if (fo) outs++;
      if (!b32.out_ready && !b32.in_ready) saw_full = 1'b1;
      cyc++;
    end
    check_eq("bp_outs", 64'(outs), 64'd6);
    check_eq("bp_full", 64'(saw_full), 64'd1);

    // Two ops held under backpressure, then reset drops them.
    step32(1'b1, rnd_stim(32), 1'b0, fi, fo);
    step32(1'b1, rnd_stim(32), 1'b0, fi, fo);
    check_eq("rst_held", 64'(q32.size()), 64'd2);
    @(negedge clk);
    rst = 1'b1;
    b32.out_ready = 1'b1;
    #1;
    check_eq("rst_mid_ovld", 64'(b32.out_valid), 64'd0);
    check_eq("rst_mid_rdy", 64'(b32.in_ready), 64'd0);
    q32.delete();
    stall32 = 1'b0;
    stall16 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    b32.in_valid = 1'b0;
    repeat (4) step32(1'b0, s, 1'b1, fi, fo);

    sent = 0; cyc = 0;
    while (sent < 200 && cyc < 4000) begin
      step32($urandom_range(0, 3) != 0, rnd_stim(32), $urandom_range(0, 3) != 0, fi, fo);
      if (fi) sent++;
      cyc++;
    end
    check_eq("sent32", 64'(sent), 64'd200);
    repeat (6) step32(1'b0, s, 1'b1, fi, fo);
    check_eq("drain32", 64'(q32.size()), 64'd0);

    sent = 0; cyc = 0;
    while (sent < 200 && cyc < 4000) begin
      step16($urandom_range(0, 3) != 0, rnd_stim(16), $urandom_range(0, 3) != 0, fi, fo);
      if (fi) sent++;
      cyc++;
    end
    check_eq("sent16", 64'(sent), 64'd200);
    repeat (6) step16(1'b0, s, 1'b1, fi, fo);
    check_eq("drain16", 64'(q16.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
